// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_ctrl (with helper s_box)
// Brief    : AES-128 key expansion into an 11-entry round-key cache with
//            one-cycle pipelined random-access reads.
// Revision : 1.0 - initial release
// ============================================================================

module s_box (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (= product of x^2..x^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

module aes_key_sched_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         key_clear,
    output logic         keys_ready,
    output logic         busy,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic         rd_valid,
    output logic [127:0] rd_data,
    output logic         rd_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_expand = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [3:0] c_last      = 4'(NR);

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [3:0]   r_cnt;
    logic [127:0] r_slot [0:NR];
    logic [127:0] r_prev;
    logic         r_keys_ready;
    logic         r_busy;
    logic         r_rd_valid;
    logic         r_rd_err;
    logic [127:0] r_rd_data;

    logic         w_accept;
    logic         w_rd_legal;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;

    assign key_ready  = (r_state != c_st_expand);
    assign w_accept   = key_valid && key_ready && !key_clear;
    assign w_rd_legal = r_keys_ready && (rd_idx <= c_last);

    // r_prev mirrors the most recently written slot, avoiding a wide read mux.
    assign w_rot = {r_prev[23:0], r_prev[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        s_box u_sbox (
            .i_byte (w_rot[31-8*j -: 8]),
            .o_byte (w_sub[31-8*j -: 8])
        );
    end

    always_comb begin
        w_rcon = 8'h00;
        case (r_cnt)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_temp = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0   = r_prev[127:96] ^ w_temp;
    assign w_n1   = r_prev[95:64]  ^ w_n0;
    assign w_n2   = r_prev[63:32]  ^ w_n1;
    assign w_n3   = r_prev[31:0]   ^ w_n2;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (key_clear)     w_state_next = c_st_idle;
                else if (w_accept) w_state_next = c_st_expand;
            end
            c_st_expand: begin
                if (key_clear)             w_state_next = c_st_idle;
                else if (r_cnt == c_last)  w_state_next = c_st_done;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) r_slot[i] <= '0;
            r_prev       <= '0;
            r_cnt        <= '0;
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_err     <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            // Reads see the pre-update buffer, so they are resolved before any clear/accept.
            r_rd_valid <= rd_en;
            r_rd_err   <= rd_en && !w_rd_legal;
            r_rd_data  <= (rd_en && w_rd_legal) ? r_slot[rd_idx] : '0;

            if (key_clear) begin
                for (int i = 0; i <= int'(NR); i++) r_slot[i] <= '0;
                r_prev       <= '0;
                r_cnt        <= '0;
                r_keys_ready <= 1'b0;
                r_busy       <= 1'b0;
            end else if (w_accept) begin
                r_slot[0]    <= key_in;
                r_prev       <= key_in;
                r_cnt        <= 4'd1;
                r_keys_ready <= 1'b0;
                r_busy       <= 1'b1;
            end else if (r_state == c_st_expand) begin
                r_slot[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
                r_prev        <= {w_n0, w_n1, w_n2, w_n3};
                r_cnt         <= r_cnt + 4'd1;
                if (r_cnt == c_last) begin
                    r_busy       <= 1'b0;
                    r_keys_ready <= 1'b1;
                end
            end
        end
    end

    assign keys_ready = r_keys_ready;
    assign busy       = r_busy;
    assign rd_valid   = r_rd_valid;
    assign rd_err     = r_rd_err;
    assign rd_data    = r_rd_data;

endmodule
`default_nettype wire
